// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage between the instruction ROM and decode.
//
// Holds the PC and presents it on the ROM address every cycle. When the
// buffer has room, it captures the returned word together with its PC into
// a DEPTH-entry FIFO. Decode drains the FIFO head through a valid/ready
// handshake. A branch redirect empties the FIFO and restarts fetch at the
// 8-byte-aligned target.
//
// Ports:
//   clk              clock, rising edge
//   rst              synchronous reset, active low
//   ce, addr         ROM chip enable (registered) and byte address (= PC)
//   inst_i           ROM data, combinational from addr
//   branch_flag_i    redirect request, ignored while ce is still 0
//   branch_target_i  redirect byte address (low three bits dropped)
//   id_valid_o       FIFO head valid
//   id_ready_i       decode consumes the head this cycle
//   id_inst_o        head instruction, 0 when empty
//   id_pc_o          head PC, 0 when empty

// One FIFO slot: a {pc, inst} register that is written when we is high.
module inst_fetch_slot #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [INST_W-1:0] d_inst,
  output logic [ADDR_W-1:0] q_pc,
  output logic [INST_W-1:0] q_inst
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_pc   <= '0;
      q_inst <= '0;
    end else if (we) begin
      q_pc   <= d_pc;
      q_inst <= d_inst;
    end
  end

endmodule

module inst_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ce,
  output logic [ADDR_W-1:0] addr,
  input  logic [INST_W-1:0] inst_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [INST_W-1:0] id_inst_o,
  output logic [ADDR_W-1:0] id_pc_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The count must represent DEPTH itself, so it needs one extra bit.
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL   = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(8);

  logic [ADDR_W-1:0] pc;
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  count;

  logic pop, space, push, redirect;

  logic [DEPTH-1:0]             slot_we;
  logic [DEPTH-1:0][ADDR_W-1:0] slot_pc;
  logic [DEPTH-1:0][INST_W-1:0] slot_inst;

  assign addr       = pc;
  assign id_valid_o = (count != '0);

  assign pop      = id_valid_o & id_ready_i;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  // a new word while decode is draining it.
  assign space    = (count < FULL) | pop;
  assign push     = ce & space & ~branch_flag_i;
  // ce is 0 only in the first cycle after reset. A branch seen in that
  // cycle is dropped.
  assign redirect = ce & branch_flag_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc    <= RESET_PC;
      ce    <= 1'b0;
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      ce <= 1'b1;
      if (redirect) begin
        // Everything in flight belongs to the wrong path. A pop in this
        // cycle has already been taken by decode, so it is simply dropped
        // together with the rest of the FIFO.
        count <= '0;
        wptr  <= '0;
        rptr  <= '0;
        pc    <= {branch_target_i[ADDR_W-1:3], 3'b000};
      end else begin
        if (push) begin
          wptr <= wptr + PTR_W'(1);
          pc   <= pc + PC_INC;
        end
        if (pop)
          rptr <= rptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign slot_we[g] = push & (wptr == PTR_W'(g));

    inst_fetch_slot #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .we     (slot_we[g]),
      .d_pc   (pc),
      .d_inst (inst_i),
      .q_pc   (slot_pc[g]),
      .q_inst (slot_inst[g])
    );
  end

  // When the FIFO is empty the head outputs read as 0, even though the
  // slots may still hold stale data.
  assign id_inst_o = id_valid_o ? slot_inst[rptr] : '0;
  assign id_pc_o   = id_valid_o ? slot_pc[rptr]   : '0;

endmodule
